alu_result_queue: RTL and testbench
===================================

ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 Parameter DEPTH, default 4, result queue entries; SHALL be a power of two, 2..16.
REQ-002 Clock and reset SHALL be one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  reset, active low.
REQ-003 in_valid  in  1  operation request valid.
REQ-004 in_ready  out  1  block accepts request this cycle.
REQ-005 in_a, in_b  in  8 each  operands.
REQ-006 in_sel  in  4  ALU operation select.
REQ-007 alu_a, alu_b  out  8 each  registered operands driven to the ALU.
REQ-008 alu_sel  out  4  registered select driven to the ALU.
REQ-009 alu_result  in  9  combinational ALU result, sampled one cycle after issue.
REQ-010 out_valid  out  1  queue head valid.
REQ-011 out_ready  in  1  consumer takes head this cycle.
REQ-012 out_result  out  9  head result; out_sel  out  4  head select.
REQ-013 out_zero, out_carry, out_err  out  1 each  head flags.
REQ-014 count  out  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-015 FSM SHALL have two states: IDLE, EXEC.
REQ-016 in_ready SHALL equal (state==IDLE) && (count<DEPTH) && rst_n.
REQ-017 Accept when in_valid && in_ready: at that edge alu_a/alu_b/alu_sel load in_a/in_b/in_sel; state -> EXEC.
REQ-018 In EXEC, at the next edge, alu_result and flags SHALL be written to the queue tail; state -> IDLE.
REQ-019 alu_a/alu_b/alu_sel SHALL hold their values until the next accept.
REQ-020 Throughput SHALL be one operation per two cycles; accept at edge N -> queue write at edge N+1 -> out_valid high after edge N+1 if queue was empty.
REQ-021 Queue SHALL be first-word-fall-through; out_* reflect the head entry whenever out_valid=1.
REQ-022 Pop occurs when out_valid && out_ready; head pointer advances at that edge.
REQ-023 Simultaneous write and pop SHALL leave count unchanged and preserve order.
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-025 out_valid SHALL equal (count!=0); out_ready with empty queue SHALL be ignored.
REQ-026 out_carry SHALL equal stored result bit 8; out_zero SHALL be 1 iff stored result bits [7:0]==0.
REQ-027 A full queue SHALL deassert in_ready; an accepted op SHALL always have a free slot at its EXEC write.

Reset
REQ-028 While rst_n=0 at a rising edge: state=IDLE, pointers=0, count=0, alu_a=alu_b=0, alu_sel=0.
REQ-029 After reset, out_valid=0 and out flags=0; queue contents are discarded.
REQ-030 Reset asserted during EXEC SHALL abort the operation; no queue write SHALL occur.

Configuration
REQ-031 Macro ALU_RQ_DIV0_CHECK_EN: when defined, an op with sel=4'b0011 and b=0 SHALL be stored with result=9'h1FF and err=1.
REQ-032 When ALU_RQ_DIV0_CHECK_EN is undefined, alu_result SHALL be stored unmodified and out_err SHALL be tied to 0.

Verification
REQ-033 Reset then a=8'd200, b=8'd100, sel=0000 -> two cycles later out_result=9'h12C, carry=1, zero=0.
REQ-034 a=8'h55, b=8'h55, sel=1111 -> out_result=9'd1; then sel=1010 -> out_result=0, zero=1, in FIFO order.
REQ-035 out_ready=0, DEPTH=4, five ops offered -> 4 stored, count=4, in_ready=0; one pop -> fifth accepted, order preserved.
REQ-036 Full queue with out_ready=1 and a write landing the same edge -> count stays constant, no loss.
REQ-037 With the macro defined, a=8'd9, b=0, sel=0011 -> out_result=9'h1FF, err=1; without it, err=0.
REQ-038 rst_n low in the cycle after an accept -> count=0, out_valid=0, and no entry appears.

Source files
------------

// File: rtl/alu_result_queue_if.sv
// Bundle of request, ALU and result-queue signals for alu_result_queue.
// Both channels use valid/ready: a transfer happens on the rising edge where valid && ready are both high.
interface alu_result_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_a;
    logic [7:0]    in_b;
    logic [3:0]    in_sel;

    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [3:0]    alu_sel;
    logic [8:0]    alu_result;

    logic          out_valid;
    logic          out_ready;
    logic [8:0]    out_result;
    logic [3:0]    out_sel;
    logic          out_zero;
    logic          out_carry;
    logic          out_err;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_a, in_b, in_sel, alu_result, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_result,
               out_sel, out_zero, out_carry, out_err, count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, alu_result, out_ready,
        output in_ready, alu_a, alu_b, alu_sel, out_valid, out_result,
               out_sel, out_zero, out_carry, out_err, count
    );
endinterface

// File: rtl/alu_result_queue.sv
// Issues one ALU operation every two cycles and queues the results in a first-word-fall-through FIFO.
// Optional feature macro: ALU_RQ_DIV0_CHECK_EN (divide-by-zero results stored as 9'h1FF with err=1).
module alu_result_queue #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_result_queue_if.slave bus,
    output logic              state_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    state_e          state_q;
    logic [7:0]      alu_a_q;
    logic [7:0]      alu_b_q;
    logic [3:0]      alu_sel_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [8:0]      res_mem_q [DEPTH];
    logic [3:0]      sel_mem_q [DEPTH];

    logic            out_valid;
    logic            accept;
    logic            wr_en;
    logic            pop;
    logic [8:0]      wr_result;
    logic [8:0]      head_result;

    assign out_valid    = (count_q != '0);
    assign bus.in_ready = (state_q == IDLE) && (count_q < DEPTH_C) && rst_n;
    assign accept       = bus.in_valid && bus.in_ready;
    // The slot was reserved when the op was accepted, so the EXEC write never meets a full queue.
    assign wr_en        = (state_q == EXEC);
    assign pop          = out_valid && bus.out_ready;

`ifdef ALU_RQ_DIV0_CHECK_EN
    logic err_mem_q [DEPTH];
    logic wr_err;

    always_comb begin
        wr_result = bus.alu_result;
        wr_err    = 1'b0;
        if (alu_sel_q == 4'b0011 && alu_b_q == 8'd0) begin
            wr_result = 9'h1FF;
            wr_err    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            err_mem_q[wr_ptr_q] <= wr_err;
        end
    end

    assign bus.out_err = out_valid & err_mem_q[rd_ptr_q];
`else
    assign wr_result   = bus.alu_result;
    assign bus.out_err = 1'b0;
`endif

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_a_q   <= bus.in_a;
                        alu_b_q   <= bus.in_b;
                        alu_sel_q <= bus.in_sel;
                        state_q   <= EXEC;
                    end
                end
                EXEC:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is not reset; a reset in EXEC simply suppresses the pending write.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            res_mem_q[wr_ptr_q] <= wr_result;
            sel_mem_q[wr_ptr_q] <= alu_sel_q;
        end
    end

    assign head_result    = res_mem_q[rd_ptr_q];
    assign bus.out_valid  = out_valid;
    assign bus.out_result = out_valid ? head_result : 9'd0;
    assign bus.out_sel    = out_valid ? sel_mem_q[rd_ptr_q] : 4'd0;
    assign bus.out_carry  = out_valid & head_result[8];
    assign bus.out_zero   = out_valid & (head_result[7:0] == 8'd0);
    assign bus.count      = count_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign state_o        = (state_q == EXEC);
endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: vector table plus hand-written FIFO, full, and reset sequences.
module tb_alu_result_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [8:0] res;
        logic       zero;
        logic       carry;
        logic       err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic state_dbg;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] exp_q[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    alu_result_queue_if #(.DEPTH(DEPTH)) ifc ();

    alu_result_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (ifc),
        .state_o (state_dbg)
    );

    // Reference ALU: 0000 add, 0001 sub, 0010 and, 0011 div (b=0 -> 0FF), 1010 xor, 1111 equal.
    always_comb begin
        case (ifc.alu_sel)
            4'b0000: ifc.alu_result = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b};
            4'b0001: ifc.alu_result = {1'b0, ifc.alu_a} - {1'b0, ifc.alu_b};
            4'b0010: ifc.alu_result = {1'b0, ifc.alu_a & ifc.alu_b};
            4'b0011: ifc.alu_result = (ifc.alu_b == 8'd0) ? 9'h0FF : {1'b0, ifc.alu_a / ifc.alu_b};
            4'b1010: ifc.alu_result = {1'b0, ifc.alu_a ^ ifc.alu_b};
            4'b1111: ifc.alu_result = {8'd0, (ifc.alu_a == ifc.alu_b)};
            default: ifc.alu_result = 9'd0;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge just after the accepting rising edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        int n;
        n = 0;
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_sel   = sel;
        ifc.in_valid = 1'b1;
        while (!ifc.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 32'(ifc.in_ready), 32'd1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [8:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'd0;
        check({name, "_valid"}, 32'(ifc.out_valid), 32'd1);
        check(name, 32'(ifc.out_result), 32'(e));
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h80, 8'h80, 4'b0000, 9'h100, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 8'h00, 4'b0000, 9'h000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 4'b0001, 9'h1F0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hF0, 8'h0F, 4'b0010, 9'h000, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'h0F, 4'b1010, 9'h0F0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h55, 8'h54, 4'b1111, 9'h000, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h64, 8'h07, 4'b0011, 9'h00E, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 4'b0000, 9'h1FE, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{8'h05, 8'h00, 4'b0011, 9'h0FF, 1'b0, 1'b0, 1'b0};
`ifdef ALU_RQ_DIV0_CHECK_EN
        vecs[9] = '{8'h09, 8'h00, 4'b0011, 9'h1FF, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{8'h05, 8'h00, 4'b0011, 9'h1FF, 1'b0, 1'b1, 1'b1};
`else
        vecs[9] = '{8'h09, 8'h00, 4'b0011, 9'h0FF, 1'b0, 1'b0, 1'b0};
`endif

        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.in_sel    = '0;
        ifc.out_ready = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_count", 32'(ifc.count), 32'd0);
        check("rst_alu_a", 32'(ifc.alu_a), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);

        // Latency of a single add: accept edge N, visible after edge N+1
        issue(8'd200, 8'd100, 4'b0000);
        check("lat_exec_state", 32'(state_dbg), 32'd1);
        check("lat_exec_ready", 32'(ifc.in_ready), 32'd0);
        check("lat_not_yet_valid", 32'(ifc.out_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(ifc.out_valid), 32'd1);
        check("lat_result", 32'(ifc.out_result), 32'h12C);
        check("lat_carry", 32'(ifc.out_carry), 32'd1);
        check("lat_zero", 32'(ifc.out_zero), 32'd0);
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        check("lat_drained", 32'(ifc.count), 32'd0);

        // Vector table: one op at a time
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sel);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 32'(ifc.out_valid), 32'd1);
            check($sformatf("vec%0d_result", i), 32'(ifc.out_result), 32'(vecs[i].res));
            check($sformatf("vec%0d_zero", i), 32'(ifc.out_zero), 32'(vecs[i].zero));
            check($sformatf("vec%0d_carry", i), 32'(ifc.out_carry), 32'(vecs[i].carry));
            check($sformatf("vec%0d_err", i), 32'(ifc.out_err), 32'(vecs[i].err));
            check($sformatf("vec%0d_sel", i), 32'(ifc.out_sel), 32'(vecs[i].sel));
            check($sformatf("vec%0d_alu_a_hold", i), 32'(ifc.alu_a), 32'(vecs[i].a));
            ifc.out_ready = 1'b1;
            @(negedge clk);
            ifc.out_ready = 1'b0;
            check($sformatf("vec%0d_empty", i), 32'(ifc.count), 32'd0);
        end

        // FIFO order of two results
        issue(8'h55, 8'h55, 4'b1111);
        exp_q.push_back(9'd1);
        issue(8'h55, 8'h55, 4'b1010);
        exp_q.push_back(9'd0);
        @(negedge clk);
        check("fifo_count2", 32'(ifc.count), 32'd2);
        pop_check("fifo_first");
        check("fifo_second_zero", 32'(ifc.out_zero), 32'd1);
        pop_check("fifo_second");
        check("fifo_empty", 32'(ifc.out_valid), 32'd0);

        // Fill to DEPTH, fifth op held off until a pop
        for (int i = 0; i < 4; i++) begin
            issue(8'(i + 1), 8'd1, 4'b0000);
            exp_q.push_back(9'(i + 2));
        end
        @(negedge clk);
        check("full_count", 32'(ifc.count), 32'd4);
        check("full_in_ready", 32'(ifc.in_ready), 32'd0);
        ifc.in_a     = 8'd10;
        ifc.in_b     = 8'd1;
        ifc.in_sel   = 4'b0000;
        ifc.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("full_blocked_count", 32'(ifc.count), 32'd4);
        check("full_blocked_state", 32'(state_dbg), 32'd0);
        pop_check("full_pop0");
        issue(8'd10, 8'd1, 4'b0000);
        exp_q.push_back(9'd11);
        @(negedge clk);
        check("refill_count", 32'(ifc.count), 32'd4);

        // Pop and write on the same edge keep the count
        pop_check("simul_pop1");
        issue(8'd20, 8'd1, 4'b0000);
        exp_q.push_back(9'd21);
        pop_check("simul_pop2");
        check("simul_count", 32'(ifc.count), 32'd3);
        while (exp_q.size() > 0) pop_check("drain");
        check("drain_count", 32'(ifc.count), 32'd0);

        // Reset during EXEC with an entry already queued
        issue(8'h55, 8'h55, 4'b1010);
        @(negedge clk);
        check("pre_rst_zero", 32'(ifc.out_zero), 32'd1);
        issue(8'd3, 8'd4, 4'b0000);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_count", 32'(ifc.count), 32'd0);
        check("abort_valid", 32'(ifc.out_valid), 32'd0);
        check("abort_zero", 32'(ifc.out_zero), 32'd0);
        check("abort_alu_a", 32'(ifc.alu_a), 32'd0);
        check("abort_state", 32'(state_dbg), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_no_entry_count", 32'(ifc.count), 32'd0);
        check("abort_no_entry_valid", 32'(ifc.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
